lif_stream_loader: RTL

Host-side transmitter for the LIF neuron tile's byte-serial load protocol. It takes a full weight vector and input vector in parallel and streams them into the neuron as 8-bit beats, with the weight/input select and load/run mode lines driven to match. It then holds the neuron in run mode for a programmed number of integrate cycles and counts the spikes it emits. It sits between a test/host controller and the neuron's `ui_in` / `uio_in[1:0]` / `uo_out[0]` pins.

---
 rtl/lif_pkg.sv | 22 ++
 rtl/lif_beat_serializer.sv | 44 ++++
 rtl/lif_stream_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants for the LIF neuron tile and its host-side stream loader.
package lif_pkg;

  localparam logic [7:0] LIF_INIT_THRESHOLD = 8'd4;
  localparam logic       LIF_WEIGHT_RESET   = 1'b0;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LOAD_W = 3'd1,
    LD_LOAD_X = 3'd2,
    LD_RUN    = 3'd3,
    LD_DONE   = 3'd4
  } lif_ld_state_t;

  // Vectors of 8 bits or fewer still need one whole beat.
  function automatic int lif_bytes(input int n_stages);
    int inputs;
    inputs = 1 << n_stages;
    return (inputs > 8) ? (inputs / 8) : 1;
  endfunction

endpackage

// File: rtl/lif_beat_serializer.sv
// MSB-first byte serializer: holds one vector and presents it as 8-bit beats.
module lif_beat_serializer
  import lif_pkg::*;
#(
  parameter  int N_STAGES = 4,
  localparam int INPUTS   = 2 ** N_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [INPUTS-1:0] vec,
  output logic [7:0]        data,
  output logic              last
);

  localparam int BYTES = lif_bytes(N_STAGES);
  localparam int W     = BYTES * 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [W-1:0]  sh_r;
  logic [IW-1:0] idx_r;

  // Load zero-extends narrow vectors so they sit in the low bits of the single beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_r  <= '0;
      idx_r <= '0;
    end else if (load) begin
      sh_r  <= W'(vec);
      idx_r <= '0;
    end else if (shift) begin
      sh_r  <= sh_r << 8;
      idx_r <= idx_r + 1'b1;
    end else begin
      sh_r  <= sh_r;
      idx_r <= idx_r;
    end
  end

  assign data = sh_r[W-1 -: 8];
  assign last = (idx_r == IW'(BYTES - 1));

endmodule

// File: rtl/lif_stream_loader.sv
// Streams weight/input vectors into the LIF tile, runs it, and counts its spikes.
module lif_stream_loader
  import lif_pkg::*;
#(
  parameter  int N_STAGES = 4,
  parameter  int RUN_W    = 8,
  localparam int INPUTS   = 2 ** N_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_weights,
  input  logic [INPUTS-1:0] w_in,
  input  logic [INPUTS-1:0] x_in,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              spike_in,
  output logic [7:0]        data_out,
  output logic              sel_weights,
  output logic              ctl_run,
  output logic              busy,
  output logic              done,
  output logic [RUN_W-1:0]  spike_count
);

  lif_ld_state_t     state_r;
  logic [INPUTS-1:0] x_r;
  logic [RUN_W-1:0]  rc_r;
  logic [RUN_W-1:0]  run_cnt_r;
  logic [RUN_W-1:0]  spike_count_r;

  logic              ser_load_s;
  logic              ser_shift_s;
  logic [INPUTS-1:0] ser_vec_s;
  logic [7:0]        ser_data_s;
  logic              ser_last_s;

  // Serializer gets weights-or-inputs at accept, and the captured inputs after the last weight beat.
  always_comb begin
    ser_load_s  = 1'b0;
    ser_shift_s = 1'b0;
    ser_vec_s   = x_r;
    case (state_r)
      LD_IDLE: begin
        ser_load_s = start;
        ser_vec_s  = load_weights ? w_in : x_in;
      end
      LD_LOAD_W: begin
        ser_load_s  = ser_last_s;
        ser_shift_s = ~ser_last_s;
      end
      LD_LOAD_X: begin
        ser_shift_s = ~ser_last_s;
      end
      default: begin
        ser_load_s  = 1'b0;
        ser_shift_s = 1'b0;
      end
    endcase
  end

  lif_beat_serializer #(.N_STAGES(N_STAGES)) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (ser_load_s),
    .shift (ser_shift_s),
    .vec   (ser_vec_s),
    .data  (ser_data_s),
    .last  (ser_last_s)
  );

  // Transaction FSM with run-length and spike counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= LD_IDLE;
      x_r           <= '0;
      rc_r          <= '0;
      run_cnt_r     <= '0;
      spike_count_r <= '0;
    end else begin
      case (state_r)
        LD_IDLE: begin
          if (start) begin
            x_r           <= x_in;
            rc_r          <= run_cycles;
            run_cnt_r     <= '0;
            spike_count_r <= '0;
            state_r       <= load_weights ? LD_LOAD_W : LD_LOAD_X;
          end
        end
        LD_LOAD_W: begin
          if (ser_last_s) state_r <= LD_LOAD_X;
        end
        LD_LOAD_X: begin
          if (ser_last_s) state_r <= (rc_r == '0) ? LD_DONE : LD_RUN;
        end
        LD_RUN: begin
          if (spike_in) spike_count_r <= spike_count_r + 1'b1;
          run_cnt_r <= run_cnt_r + 1'b1;
          if (run_cnt_r == rc_r - 1'b1) state_r <= LD_DONE;
        end
        LD_DONE: begin
          state_r <= LD_IDLE;
        end
        default: begin
          state_r <= LD_IDLE;
        end
      endcase
    end
  end

  // Moore output decode; idle keeps the neuron in run mode so nothing stray shifts in.
  always_comb begin
    data_out    = 8'h00;
    sel_weights = 1'b0;
    ctl_run     = 1'b1;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_r)
      LD_IDLE: begin
        busy = 1'b0;
      end
      LD_LOAD_W: begin
        data_out    = ser_data_s;
        sel_weights = 1'b1;
        ctl_run     = 1'b0;
      end
      LD_LOAD_X: begin
        data_out = ser_data_s;
        ctl_run  = 1'b0;
      end
      LD_RUN: begin
        ctl_run = 1'b1;
      end
      LD_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign spike_count = spike_count_r;

endmodule
